kf8237_priority_arbiter: RTL
============================

Name: kf8237_priority_arbiter

Overview:
Channel arbiter and bus-handshake sequencer for the KF8237 DMA controller. It combines the hardware DREQ lines with the software request register, applies the mask and the fixed or rotating priority, and runs the HRQ/HLDA handshake. It drives DACK and the channel grant to the transfer-timing block. It also drives lock_bus_control, which blocks CPU register access in the bus control logic while DMA owns the bus.

Parameters:
SYNC_STAGES, 2, DREQ synchronizer depth; legal values are 1 or 2.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-high
master_clear  in  1  synchronous soft reset pulse (software master clear)
controller_disable  in  1  command register bit 2; blocks new arbitration
rotating_priority  in  1  command register bit 4; 0 = fixed, 1 = rotating
dreq_sense_active_low  in  1  command register bit 6
dack_sense_active_high  in  1  command register bit 7
mask_register  in  4  1 = channel masked (hardware DREQ only)
request_register  in  4  software request bits
dma_request  in  4  raw DREQ pins (asynchronous)
hold_acknowledge  in  1  HLDA from CPU side
service_complete  in  1  one-cycle pulse from timing block: current service finished
hold_request  out  1  HRQ
dma_acknowledge  out  4  DACK pins, polarity applied
active_channel  out  2  granted channel number
channel_grant  out  1  high while a channel owns the bus (DACK active)
clear_software_request  out  4  one-hot pulse to clear the serviced software request bit
lock_bus_control  out  1  high from HLDA-high detection until HLDA-low detection

Behaviour:
- Reset (async) and master_clear (sync) have the same effect:
  - state IDLE, priority pointer = 0, hold_request = 0, channel_grant = 0, active_channel = 0, lock_bus_control = 0, clear_software_request = 0.
  - dma_acknowledge equals the inactive level: 4'b1111 when dack_sense_active_high = 0, 4'b0000 when it is 1.
- master_clear has priority over every other event in the same cycle.
- DREQ path: dma_request passes through SYNC_STAGES flops, then XORs with {4{dreq_sense_active_low}}.
- effective_request = (sync_dreq & ~mask_register) | request_register. Software requests ignore the mask.
- Priority:
  - fixed: channel 0 is highest, channel 3 is lowest.
  - rotating: pointer P is the highest channel; order is P, P+1, P+2, P+3 mod 4.
  - On service_complete in rotating mode, P <= active_channel + 1 (mod 4). P is not updated in fixed mode.
- State machine (all outputs registered):
  - IDLE: if ~controller_disable and |effective_request, hold_request <= 1 and go to REQUEST.
  - REQUEST: hold HRQ.
    - On hold_acknowledge = 1, re-arbitrate on the current effective_request.
    - If a winner exists: latch active_channel, assert DACK and channel_grant, lock_bus_control <= 1, go to GRANT.
    - If no request remains: hold_request <= 0, lock_bus_control <= 1, go to RELEASE.
  - GRANT: outputs stable until service_complete.
    - On service_complete: DACK, channel_grant and hold_request drop, go to RELEASE.
    - If the serviced channel's request_register bit is 1, pulse clear_software_request[active_channel] for one cycle.
    - controller_disable and mask changes never abort GRANT.
  - RELEASE: wait for hold_acknowledge = 0, then lock_bus_control <= 0 and go to IDLE. No new HRQ is issued in the same cycle.
- Latency:
  - DREQ is stable before edge k; HRQ is high after edge k+SYNC_STAGES.
  - HLDA is sampled high at edge m; DACK, channel_grant and lock_bus_control are high after edge m.
- Simultaneous events:
  - service_complete outside GRANT is ignored.
  - hold_acknowledge falling during GRANT is a protocol error. Ownership is held; service_complete still closes the service.
- dma_acknowledge = onehot(active_channel) when channel_grant = 1, else 0; the result is XORed with {4{~dack_sense_active_high}}. The polarity is applied combinationally.

Decomposition:
- Shared package kf8237_pkg holds:
  - state encoding (IDLE, REQUEST, GRANT, RELEASE)
  - channel count constant (4)
  - command register bit index constants
- Sub-module kf8237_rotating_priority_encoder is natural: combinational. Inputs are request[3:0], pointer[1:0] and rotate enable; outputs are winner[1:0] and valid.

Test Plan:
- Fixed priority: DREQ = 4'b1010, mask 0, sense active-high → HRQ after 2 cycles; HLDA=1 → active_channel=1, dack_sense=0 gives dma_acknowledge=4'b1101; service_complete → HRQ=0; HLDA=0 → lock_bus_control=0.
- Rotating: DREQ = 4'b1111 held, each service completed → grant order 0,1,2,3,0; pointer wraps from 3 to 0.
- Mask and software: mask=4'b1111, DREQ=4'b1111 → no HRQ; request_register=4'b0100 → grant channel 2 and a one-cycle clear_software_request=4'b0100.
- DREQ dropped before HLDA: channel 3 requests, deasserted in REQUEST; HLDA=1 → no DACK, state RELEASE, HRQ=0.
- controller_disable=1 during GRANT → grant persists until service_complete; no new HRQ while disabled even with DREQ=4'b0001.
- Async reset and master_clear in GRANT → next cycle HRQ=0, channel_grant=0, DACK inactive, pointer=0, state IDLE.

Source files
------------

// File: rtl/kf8237_pkg.sv
// Shared definitions for the KF8237 channel arbiter: state encoding,
// channel count, command register bit positions and a one-hot helper.
package kf8237_pkg;

    localparam int NUM_CHANNELS = 4;

    localparam int CMD_BIT_CONTROLLER_DISABLE = 2;
    localparam int CMD_BIT_ROTATING_PRIORITY  = 4;
    localparam int CMD_BIT_DREQ_SENSE         = 6;
    localparam int CMD_BIT_DACK_SENSE         = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    function automatic logic [NUM_CHANNELS-1:0] onehot4(input logic [1:0] ch);
        onehot4 = 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/kf8237_rotating_priority_encoder.sv
// Combinational channel picker: fixed order 0..3, or rotating order
// starting at the priority pointer when rotate_enable is set.
module kf8237_rotating_priority_encoder
    import kf8237_pkg::*;
(
    input  logic [NUM_CHANNELS-1:0] request,
    input  logic [1:0]              pointer,
    input  logic                    rotate_enable,
    output logic [1:0]              winner,
    output logic                    valid
);

    logic [1:0] w_base;
    logic [1:0] w_idx;

    always_comb begin
        winner = 2'd0;
        valid  = 1'b0;
        w_idx  = 2'd0;
        w_base = rotate_enable ? pointer : 2'd0;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            w_idx = w_base + 2'(i);
            if (request[w_idx]) begin
                winner = w_idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/kf8237_priority_arbiter.sv
// KF8237 channel arbiter and HRQ/HLDA handshake sequencer. Drives DACK,
// the channel grant and the CPU register-access lock while DMA owns the bus.
//
// state   | meaning
// IDLE    | no bus request; waiting for an enabled effective request
// REQUEST | HRQ asserted; waiting for HLDA, then arbitrate
// GRANT   | channel owns the bus; waiting for service_complete
// RELEASE | HRQ dropped; waiting for HLDA to fall
module kf8237_priority_arbiter
    import kf8237_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    master_clear,
    input  logic                    controller_disable,
    input  logic                    rotating_priority,
    input  logic                    dreq_sense_active_low,
    input  logic                    dack_sense_active_high,
    input  logic [NUM_CHANNELS-1:0] mask_register,
    input  logic [NUM_CHANNELS-1:0] request_register,
    input  logic [NUM_CHANNELS-1:0] dma_request,
    input  logic                    hold_acknowledge,
    input  logic                    service_complete,
    output logic                    hold_request,
    output logic [NUM_CHANNELS-1:0] dma_acknowledge,
    output logic [1:0]              active_channel,
    output logic                    channel_grant,
    output logic [NUM_CHANNELS-1:0] clear_software_request,
    output logic                    lock_bus_control
);

    logic [NUM_CHANNELS-1:0] r_dreq_sync [SYNC_STAGES];
    arb_state_t              r_state;
    logic [1:0]              r_priority_pointer;
    logic                    r_hold_request;
    logic                    r_channel_grant;
    logic [1:0]              r_active_channel;
    logic                    r_lock_bus_control;
    logic [NUM_CHANNELS-1:0] r_clear_sw_request;

    logic [NUM_CHANNELS-1:0] w_sync_dreq;
    logic [NUM_CHANNELS-1:0] w_effective_request;
    logic [1:0]              w_winner;
    logic                    w_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_dreq_sync[s] <= '0;
        end else begin
            r_dreq_sync[0] <= dma_request;
            for (int s = 1; s < SYNC_STAGES; s++) r_dreq_sync[s] <= r_dreq_sync[s-1];
        end
    end

    assign w_sync_dreq         = r_dreq_sync[SYNC_STAGES-1] ^ {NUM_CHANNELS{dreq_sense_active_low}};
    // Software requests bypass the mask.
    assign w_effective_request = (w_sync_dreq & ~mask_register) | request_register;

    kf8237_rotating_priority_encoder u_encoder (
        .request       (w_effective_request),
        .pointer       (r_priority_pointer),
        .rotate_enable (rotating_priority),
        .winner        (w_winner),
        .valid         (w_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_priority_pointer <= 2'd0;
            r_hold_request     <= 1'b0;
            r_channel_grant    <= 1'b0;
            r_active_channel   <= 2'd0;
            r_lock_bus_control <= 1'b0;
            r_clear_sw_request <= '0;
        end else if (master_clear) begin
            r_state            <= ST_IDLE;
            r_priority_pointer <= 2'd0;
            r_hold_request     <= 1'b0;
            r_channel_grant    <= 1'b0;
            r_active_channel   <= 2'd0;
            r_lock_bus_control <= 1'b0;
            r_clear_sw_request <= '0;
        end else begin
            r_clear_sw_request <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!controller_disable && |w_effective_request) begin
                        r_hold_request <= 1'b1;
                        r_state        <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (hold_acknowledge) begin
                        r_lock_bus_control <= 1'b1;
                        if (w_valid) begin
                            r_active_channel <= w_winner;
                            r_channel_grant  <= 1'b1;
                            r_state          <= ST_GRANT;
                        end else begin
                            r_hold_request <= 1'b0;
                            r_state        <= ST_RELEASE;
                        end
                    end
                end
                ST_GRANT: begin
                    // HLDA loss, disable and mask changes are ignored here.
                    if (service_complete) begin
                        r_channel_grant <= 1'b0;
                        r_hold_request  <= 1'b0;
                        r_state         <= ST_RELEASE;
                        if (rotating_priority)
                            r_priority_pointer <= r_active_channel + 2'd1;
                        if (request_register[r_active_channel])
                            r_clear_sw_request <= onehot4(r_active_channel);
                    end
                end
                ST_RELEASE: begin
                    if (!hold_acknowledge) begin
                        r_lock_bus_control <= 1'b0;
                        r_state            <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hold_request           = r_hold_request;
    assign channel_grant          = r_channel_grant;
    assign active_channel         = r_active_channel;
    assign lock_bus_control       = r_lock_bus_control;
    assign clear_software_request = r_clear_sw_request;
    assign dma_acknowledge        = (r_channel_grant ? onehot4(r_active_channel) : '0)
                                    ^ {NUM_CHANNELS{~dack_sense_active_high}};

endmodule
